// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_CAP,
    MERGE,
    WR,
    RESP
  } state_t;

  // RISC-V funct3 encodings for loads and stores.
  localparam logic [2:0] F3_B  = 3'd0;  // LB / SB
  localparam logic [2:0] F3_H  = 3'd1;  // LH / SH
  localparam logic [2:0] F3_W  = 3'd2;  // LW / SW
  localparam logic [2:0] F3_BU = 3'd4;  // LBU
  localparam logic [2:0] F3_HU = 3'd5;  // LHU

  // 1 when the access has a legal funct3 and natural alignment.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = ~addr_lo[0];
        F3_W:    ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: ok = 1'b1;
        F3_H, F3_HU: ok = ~addr_lo[0];
        F3_W:        ok = (addr_lo == 2'b00);
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3/addr_lo select the lane; rdata is the memory word; wdata is
// the store data; load_data is the extended load result; merge_data is the
// memory word with the addressed byte/half replaced (or wdata for SW).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Little-endian: byte k lives at bits [8k+7:8k]; half uses addr_lo[1].
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = rdata;
    endcase

    merge_data = rdata;
    case (funct3)
      F3_B:    merge_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a word-addressed data memory with registered readData.
// Latency accept->resp: error 1, SW 2, load 3, SB/SH 4 cycles.
// Backpressure: req_ready only in IDLE (one request in flight); resp has none.
// Ports: req_* byte-addressed request from execute; resp_* one-cycle completion
// with error flag and held load data; mem_* drive the memory (mem_read_data
// arrives the cycle after mem_read).
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDRSIZE-1:0] mem_address,
  output logic [WORDSIZE-1:0] mem_write_data,
  input  logic [WORDSIZE-1:0] mem_read_data
);

  state_t               state, state_nxt;
  logic                 wr_q;
  logic                 err_q;
  logic [2:0]           f3_q;
  logic [ADDRSIZE+1:0]  addr_q;
  logic [31:0]          wbuf_q;
  logic [31:0]          resp_rdata_q;
  logic [31:0]          load_data;
  logic [31:0]          merge_data;
  logic                 legal;

  // Bytes above the memory's reach are dropped, so addresses wrap.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDRSIZE+2];

  assign legal       = access_legal(req_write, req_funct3, req_addr[1:0]);
  assign mem_address = addr_q[ADDRSIZE+1:2];
  assign resp_rdata  = resp_rdata_q;

  lsu_byte_lane u_lane (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_read_data),
    .wdata      (wbuf_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wbuf_q       <= '0;
      resp_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          wr_q   <= req_write;
          f3_q   <= req_funct3;
          addr_q <= req_addr[ADDRSIZE+1:0];
          wbuf_q <= req_wdata;  // SW writes this directly; SB/SH merge it
          err_q  <= ~legal;
          if (!legal) resp_rdata_q <= '0;
        end
        LD_CAP: resp_rdata_q <= load_data;
        MERGE:  wbuf_q       <= merge_data;
        WR:     resp_rdata_q <= '0;  // stores complete with zero data
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!legal)                             state_nxt = RESP;
          else if (req_write && req_funct3 == F3_W) state_nxt = WR;
          else                                    state_nxt = RD;
        end
      end
      RD: begin
        mem_read  = 1'b1;
        state_nxt = wr_q ? MERGE : LD_CAP;
      end
      LD_CAP: state_nxt = RESP;
      MERGE:  state_nxt = WR;
      WR: begin
        mem_write      = 1'b1;
        mem_write_data = wbuf_q;
        state_nxt      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit that drives the single-cycle core's word-addressed data memory (memRead/memWrite/address/writeData, registered readData). Accepts one byte-addressed RISC-V load or store at a time from the execute stage. Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores. Rejects misaligned or illegal accesses without touching memory.

## Interface

Parameters:
- ADDRSIZE, 5, word-address width; memory depth 2^ADDRSIZE words.
- WORDSIZE, 32, data width; fixed at 32 (byte lanes assume 4 bytes).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on a clk edge with req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal funct3.
- resp_rdata  out  32  load result; 0 for stores and errors; held until next response.
- mem_read  out  1  to memory memRead.
- mem_write  out  1  to memory memWrite.
- mem_address  out  ADDRSIZE  word index = req_addr[ADDRSIZE+1:2].
- mem_write_data  out  32  to memory writeData.
- mem_read_data  in  32  from memory readData; valid the cycle after mem_read.

## Operation

- Request fields are captured into registers at the accept edge. All mem_* outputs are decoded from state and captured registers only, never from req_* directly.
- Legality:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Load funct3 3/6/7 is illegal.
  - Store funct3 >2 is illegal.
- Address bits above ADDRSIZE+1 are ignored, so addresses wrap modulo 2^(ADDRSIZE+2) bytes.
- States:
  - IDLE: req_ready=1. On accept: illegal -> RESP with err; load or SB/SH -> RD; SW -> WR.
  - RD: mem_read=1. -> LD_CAP if load, MERGE if store.
  - LD_CAP: lane select on mem_read_data by addr[1:0]/addr[1], extend, register into resp_rdata. -> RESP.
  - MERGE: replace the addressed byte/half of mem_read_data with req_wdata low bits, register the result into the write buffer. -> WR.
  - WR: mem_write=1, mem_write_data = write buffer (SW: captured req_wdata). -> RESP.
  - RESP: resp_valid=1. -> IDLE.
- Lane order is little-endian: byte k = bits [8k+7:8k].
- mem_read and mem_write are never both high.

## Timing

- Cycle 0 = accept edge's cycle.
- Latency from accept to resp_valid:
  - Error: cycle 1.
  - SW: mem_write in cycle 1, resp in cycle 2.
  - Load: mem_read in cycle 1, capture in cycle 2, resp in cycle 3.
  - SB/SH: read in cycle 1, merge in cycle 2, write in cycle 3, resp in cycle 4.
- Throughput: next accept is possible in the RESP cycle's following cycle (IDLE).
- req_valid while not ready is ignored and must be held by the requester.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Reset mid-operation: all outputs drop asynchronously and no partial write ever issues. The memory shares the same reset.

## Structure

- Package lsu_pkg holds:
  - state enum (IDLE, RD, LD_CAP, MERGE, WR, RESP);
  - funct3 constants;
  - a legality function.
- Sub-module lsu_byte_lane (combinational) provides load extract/extend and store merge, both indexed by funct3 and addr[1:0].
- FSM and registers live in the top level.

## Test plan

- After reset, SW 0x08 data 0xDEADBEEF -> cycle 1 mem_write, mem_address 2, data 0xDEADBEEF; resp cycle 2. Then LW 0x08 -> resp_rdata 0xDEADBEEF at cycle 3.
- On that word:
  - LB 0x09 -> 0xFFFFFFBE
  - LBU 0x09 -> 0x000000BE
  - LH 0x0A -> 0xFFFFDEAD
  - LHU 0x0A -> 0x0000DEAD
- SB 0x0B data 0x12 -> read then write 0x12ADBEEF. Then SH 0x08 data 0x5678 -> 0x12AD5678; confirmed by LW.
- LW 0x06, SH 0x03, load funct3 3 -> each gives resp_err=1 at cycle 1, resp_rdata 0, no mem_read/mem_write.
- SW 0x80 data 1 (ADDRSIZE=5) -> mem_address 0; LW 0x00 returns 1.
- reset asserted during MERGE of an SB -> mem_write never asserts, outputs at reset values immediately; req_ready=1 after release; LW returns 0.
